// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/response bundle between the datapath and the
// iterative multiply/divide unit.
//   start, alu_ctrl, a, b           : request from the datapath
//   busy, done, div_by_zero, stall  : status back to the datapath
//   hi, lo                          : committed HI/LO registers
//   result                          : MFHI/MFLO read-back (combinational)
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] result;

  // Unit side
  modport slave (
    input  start, alu_ctrl, a, b,
    output busy, done, div_by_zero, stall, hi, lo, result
  );

  // Datapath side
  modport master (
    output start, alu_ctrl, a, b,
    input  busy, done, div_by_zero, stall, hi, lo, result
  );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative unsigned MULTU / DIVU with architectural HI/LO.
// One radix-2 step per cycle, WIDTH steps per operation; HI/LO change only at
// commit or reset. MFHI/MFLO are served combinationally from committed HI/LO.
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : mult_div_unit_if.slave (request, status, HI/LO, result)
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clock,
  input  logic           reset,
  mult_div_unit_if.slave bus
);

  localparam int unsigned W2    = 2 * WIDTH;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  localparam logic [3:0] MULTU_AC = 4'd7;
  localparam logic [3:0] DIVU_AC  = 4'd8;
  localparam logic [3:0] MFHI_AC  = 4'd9;
  localparam logic [3:0] MFLO_AC  = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             op_div_q, op_div_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             accept_c;
  logic [WIDTH:0]   mul_sum;
  logic [W2-1:0]    mul_next;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_diff;
  logic             rem_ge;
  logic [W2-1:0]    div_next;
  logic [W2-1:0]    step_next;

  // New MULTU/DIVU is taken only when no operation is in flight
  assign accept_c = bus.start
                 && ((bus.alu_ctrl == MULTU_AC) || (bus.alu_ctrl == DIVU_AC))
                 && (state_q != S_RUN);

  // Multiply step: acc = {partial product, remaining multiplier bits};
  // the carry out of the upper-half add is shifted back into the MSB.
  always_comb begin
    mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, opnd_q};
    mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                        : {1'b0, acc_q[W2-1:1]};
  end

  // Restoring divide step: acc = {remainder, dividend/quotient}. The shifted
  // remainder needs WIDTH+1 bits; the kept difference always fits in WIDTH.
  always_comb begin
    rem_sh   = acc_q[W2-1:WIDTH-1];
    rem_ge   = (rem_sh >= {1'b0, opnd_q});
    rem_diff = WIDTH'(rem_sh - {1'b0, opnd_q});
    div_next = rem_ge ? {rem_diff, acc_q[WIDTH-2:0], 1'b1}
                      : {acc_q[W2-2:0], 1'b0};
  end

  assign step_next = op_div_q ? div_next : mul_next;

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    op_div_d = op_div_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    count_d  = count_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_c) begin
          op_div_d = (bus.alu_ctrl == DIVU_AC);
          // Divide seeds the low half with the dividend, multiply with the multiplier
          acc_d    = (bus.alu_ctrl == DIVU_AC) ? {{WIDTH{1'b0}}, bus.a}
                                               : {{WIDTH{1'b0}}, bus.b};
          opnd_d   = (bus.alu_ctrl == DIVU_AC) ? bus.b : bus.a;
          count_d  = '0;
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end

      S_RUN: begin
        if (op_div_q && (opnd_q == '0)) begin
          // Divide by zero short-circuits: HI keeps the dividend, LO all ones
          hi_d    = acc_q[WIDTH-1:0];
          lo_d    = {WIDTH{1'b1}};
          dbz_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          acc_d   = step_next;
          count_d = count_q + CNT_W'(1);
          if (count_q == LAST_CNT) begin
            hi_d    = step_next[W2-1:WIDTH];
            lo_d    = step_next[WIDTH-1:0];
            state_d = S_DONE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_div_q <= 1'b0;
      acc_q    <= '0;
      opnd_q   <= '0;
      count_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_div_q <= op_div_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      count_q  <= count_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

  // Stall covers the accept cycle as well as the whole run
  assign bus.stall = (state_q == S_RUN) || accept_c;

  // Move-from reads the committed registers, so in-flight work is never visible
  assign bus.result = (bus.alu_ctrl == MFHI_AC) ? hi_q :
                      (bus.alu_ctrl == MFLO_AC) ? lo_q : '0;

endmodule
